// File: rtl/max_pool2_pkg.sv
// Shared constants and helpers for the max_pool2 stage (also used by conv2 / full_conn).
package max_pool2_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned Q_FRAC     = 16;          // Q16.16 fraction bits
    localparam int unsigned FMAP_DIM   = 10;          // conv2 output width = height
    localparam int unsigned POOL_DIM   = FMAP_DIM / 2;
    localparam int unsigned FMAP_DEPTH = 16;
    localparam int unsigned POS_W      = 3;           // holds 0..POOL_DIM-1
    localparam int unsigned CH_W       = 4;           // holds 0..FMAP_DEPTH-1

    localparam logic [ADDR_W-1:0] SRC_BASE_ADDR = 18'd196608;
    localparam logic [ADDR_W-1:0] DST_BASE_ADDR = 18'd65536;

    typedef enum logic [1:0] {StIdle, StPool, StDrain, StDone} state_t;

    // Feature maps are stored as {z, y, x} with 5-bit y/x fields.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CH_W-1:0]   z,
                                                    input logic [4:0]        y,
                                                    input logic [4:0]        x);
        return base + {4'd0, z, y, x};
    endfunction

endpackage

// File: rtl/max_pool2_agen.sv
// Read-side address generator: walks window/ox/oy/z and packs the source address.
module max_pool2_agen
    import max_pool2_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SRC_BASE = SRC_BASE_ADDR,
    parameter int unsigned       IN_DIM   = FMAP_DIM,
    parameter int unsigned       DEPTH    = FMAP_DEPTH
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              run,
    output logic [1:0]        w,
    output logic [POS_W-1:0]  ox,
    output logic [POS_W-1:0]  oy,
    output logic [CH_W-1:0]   z,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(IN_DIM / 2 - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DEPTH - 1);

    logic       w_wrap, ox_wrap, oy_wrap, z_wrap;
    logic [4:0] y_pix, x_pix;

    assign w_wrap  = (w == 2'd3);
    assign ox_wrap = (ox == POS_LAST);
    assign oy_wrap = (oy == POS_LAST);
    assign z_wrap  = (z == CH_LAST);

    // Window position fastest, then ox, oy, z; everything parks at 0 outside POOL.
    always_ff @(posedge clk) begin
        if (!srstn || !run) begin
            w  <= '0;
            ox <= '0;
            oy <= '0;
            z  <= '0;
        end else begin
            w <= w + 2'd1;
            if (w_wrap) begin
                ox <= ox_wrap ? '0 : ox + POS_W'(1);
                if (ox_wrap) begin
                    oy <= oy_wrap ? '0 : oy + POS_W'(1);
                    if (oy_wrap) begin
                        z <= z_wrap ? '0 : z + CH_W'(1);
                    end
                end
            end
        end
    end

    // w[1] is dy, w[0] is dx: pixel = 2*o + d.
    always_comb begin
        y_pix = 5'({oy, w[1]});
        x_pix = 5'({ox, w[0]});
        last  = run && w_wrap && ox_wrap && oy_wrap && z_wrap;
        addr  = run ? pack_addr(SRC_BASE, z, y_pix, x_pix) : '0;
    end

endmodule

// File: rtl/max_pool2.sv
// 2x2 / stride-2 max pooling of the conv2 fmap into the FC ifmap area.
module max_pool2
    import max_pool2_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DATA_W,
    parameter int unsigned           ADDR_WIDTH = ADDR_W,
    parameter logic [ADDR_WIDTH-1:0] SRC_BASE   = SRC_BASE_ADDR,
    parameter logic [ADDR_WIDTH-1:0] DST_BASE   = DST_BASE_ADDR,
    parameter int unsigned           IN_DIM     = FMAP_DIM,
    parameter int unsigned           DEPTH      = FMAP_DEPTH
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  enable,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  dram_en_rd,
    output logic                  dram_en_wr,
    output logic                  done
);

    state_t state_q, state_d;
    logic   drain_q;
    logic   run, last;

    logic [1:0]       w_a;
    logic [POS_W-1:0] ox_a, oy_a;
    logic [CH_W-1:0]  z_a;

    // Read-aligned copies of the counters (data_in arrives one cycle after the address).
    logic             rd_vld_q;
    logic [1:0]       w_q;
    logic [POS_W-1:0] ox_q, oy_q;
    logic [CH_W-1:0]  z_q;

    logic [DATA_WIDTH-1:0] max_q, win_max;
    logic                  win_end;

    // Read status is handshake-free; the strobe is accepted for sibling compatibility only.
    logic unused_dram_valid;
    assign unused_dram_valid = dram_valid;

    assign run        = (state_q == StPool);
    assign dram_en_rd = run;
    assign done       = (state_q == StDone);

    max_pool2_agen #(
        .SRC_BASE (SRC_BASE),
        .IN_DIM   (IN_DIM),
        .DEPTH    (DEPTH)
    ) u_agen (
        .clk   (clk),
        .srstn (srstn),
        .run   (run),
        .w     (w_a),
        .ox    (ox_a),
        .oy    (oy_a),
        .z     (z_a),
        .last  (last),
        .addr  (addr_in)
    );

    // State register plus the two-cycle drain counter.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= StIdle;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;
        end
    end

    // Next-state: DRAIN covers the read latency and the final write before DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StPool;
            StPool:  if (last) state_d = StDrain;
            StDrain: if (drain_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Delay valid and window coordinates by one cycle to line up with data_in.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            rd_vld_q <= 1'b0;
            w_q      <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            z_q      <= '0;
        end else begin
            rd_vld_q <= run;
            w_q      <= w_a;
            ox_q     <= ox_a;
            oy_q     <= oy_a;
            z_q      <= z_a;
        end
    end

    // Strictly-greater keeps the earlier sample on a tie.
    always_comb begin
        win_max = ($signed(data_in) > $signed(max_q)) ? data_in : max_q;
        win_end = rd_vld_q && (w_q == 2'd3);
    end

    // Running maximum; the first sample of each window overwrites it.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            max_q <= '0;
        end else if (rd_vld_q) begin
            max_q <= (w_q == 2'd0) ? data_in : win_max;
        end
    end

    // Write register: strobe for one cycle per window, data/address hold in between.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            dram_en_wr <= 1'b0;
            data_out   <= '0;
            addr_out   <= '0;
        end else begin
            dram_en_wr <= win_end;
            if (win_end) begin
                data_out <= win_max;
                addr_out <= pack_addr(DST_BASE, z_q, 5'(oy_q), 5'(ox_q));
            end
        end
    end

endmodule

// File: tb/tb_max_pool2.sv
// Self-checking bench for max_pool2: directed fmaps, timing, abort and back-to-back runs.
module tb_max_pool2;

    localparam logic [17:0] SRC = 18'd196608;
    localparam logic [17:0] DST = 18'd65536;

    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        enable = 1'b0;
    logic        dram_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [17:0] addr_in, addr_out;
    logic        dram_en_rd, dram_en_wr, done;

    always #5 clk = ~clk;

    max_pool2 dut (
        .clk        (clk),
        .srstn      (srstn),
        .enable     (enable),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .addr_in    (addr_in),
        .addr_out   (addr_out),
        .dram_en_rd (dram_en_rd),
        .dram_en_wr (dram_en_wr),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int t = 0;
    int t0 = 0;

    always @(posedge clk) t <= t + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source fmap content for each test pattern.
    function automatic logic [31:0] src_val(input int m, input int z, input int y, input int x);
        int win, p;
        win = z * 25 + (y / 2) * 5 + x / 2;
        p   = (y % 2) * 2 + (x % 2);
        if (m == 0) return 32'((z * 100 + y * 10 + x) << 16);
        if (m == 1) return (p == win % 4) ? 32'h0005_0000 : 32'h0;
        if (win % 2 == 0) begin
            case (p)
                0:       return 32'hFFFD_0000;
                1:       return 32'hFFFF_0000;
                2:       return 32'hFFFE_0000;
                default: return 32'hFFFC_0000;
            endcase
        end
        case (p)
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] exp_val(input int m, input int z, input int oy, input int ox);
        logic [31:0] best, v;
        best = src_val(m, z, 2 * oy, 2 * ox);
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = src_val(m, z, 2 * oy + dy, 2 * ox + dx);
                if ($signed(v) > $signed(best)) best = v;
            end
        return best;
    endfunction

    // DRAM model: one-cycle read latency.
    always @(posedge clk) begin
        logic [17:0] off;
        off = addr_in - SRC;
        if (dram_en_rd) data_in <= src_val(mode, int'(off[13:10]), int'(off[9:5]), int'(off[4:0]));
    end

    // Monitor state
    bit          mon_on = 1'b0;
    int          rd_count, first_rd, last_rd, rd_after_done;
    int          wr_count, first_wr, last_wr, done_count, done_cyc0, done_cyc1;
    int          late_events, idle_addr_bad, abort_cyc;
    logic [17:0] first_wr_addr;
    logic [31:0] out_mem [400];

    task automatic clear_mon();
        rd_count = 0; first_rd = -1; last_rd = -1; rd_after_done = -1;
        wr_count = 0; first_wr = -1; last_wr = -1;
        done_count = 0; done_cyc0 = -1; done_cyc1 = -1;
        late_events = 0; idle_addr_bad = 0; abort_cyc = 1 << 30;
        first_wr_addr = '0;
        for (int i = 0; i < 400; i++) out_mem[i] = 32'hDEAD_BEEF;
    endtask

    // Sample DUT outputs on the falling edge.
    always @(negedge clk) begin
        int rel, idx, z, oy, ox;
        logic [17:0] off;
        if (mon_on) begin
            rel = t - t0;
            if (dram_en_rd) begin
                if (rd_count == 0) first_rd = rel;
                if (done_count >= 1 && rd_after_done < 0) rd_after_done = rel;
                last_rd = rel;
                rd_count++;
                if (rel > abort_cyc) late_events++;
            end else if (addr_in != 18'd0) begin
                idle_addr_bad++;
            end
            if (dram_en_wr) begin
                idx = wr_count % 400;
                z = idx / 25; oy = (idx / 5) % 5; ox = idx % 5;
                if (wr_count == 0) begin
                    first_wr = rel;
                    first_wr_addr = addr_out;
                end
                last_wr = rel;
                check("wr_addr", 64'(addr_out), 64'(DST + 18'((z << 10) + (oy << 5) + ox)));
                check("wr_data", 64'(data_out), 64'(exp_val(mode, z, oy, ox)));
                off = addr_out - DST;
                if (off[9:5] < 5 && off[4:0] < 5)
                    out_mem[int'(off[13:10]) * 25 + int'(off[9:5]) * 5 + int'(off[4:0])] = data_out;
                wr_count++;
                if (rel > abort_cyc) late_events++;
            end
            if (done) begin
                if (done_count == 0) done_cyc0 = rel;
                else done_cyc1 = rel;
                done_count++;
                if (rel > abort_cyc) late_events++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        tick();
        clear_mon();
        t0 = t;
        enable = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic wait_rel(input int r);
        while (t - t0 < r) tick();
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        while (done_count < n && c < budget) begin
            tick();
            c++;
        end
        check("done_within_budget", 64'(done_count >= n), 64'd1);
    endtask

    typedef struct {
        int          m;
        int          z;
        int          oy;
        int          ox;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vec [NVEC];

    task automatic check_table(input int m);
        for (int i = 0; i < NVEC; i++)
            if (vec[i].m == m)
                check($sformatf("table_m%0d_z%0d_y%0d_x%0d", m, vec[i].z, vec[i].oy, vec[i].ox),
                      64'(out_mem[vec[i].z * 25 + vec[i].oy * 5 + vec[i].ox]), 64'(vec[i].exp));
    endtask

    task automatic check_pass();
        check("rd_count", 64'(rd_count), 64'd1600);
        check("first_rd", 64'(first_rd), 64'd1);
        check("last_rd", 64'(last_rd), 64'd1600);
        check("wr_count", 64'(wr_count), 64'd400);
        check("first_wr", 64'(first_wr), 64'd6);
        check("first_wr_addr", 64'(first_wr_addr), 64'(DST));
        check("last_wr", 64'(last_wr), 64'd1602);
        check("done_count", 64'(done_count), 64'd1);
        check("done_cyc", 64'(done_cyc0), 64'd1603);
        check("idle_addr_zero", 64'(idle_addr_bad), 64'd0);
    endtask

    task automatic run_pass(input int m, input bit pulse_mid);
        mode = m;
        start();
        tick();
        enable = 1'b0;
        if (pulse_mid) begin
            enable = 1'b1;               // cycle 1: already in POOL
            tick();
            enable = 1'b0;
            wait_rel(800);
            enable = 1'b1;
            tick();
            enable = 1'b0;
        end
        wait_done(1, 2000);
        repeat (3) tick();
        check_pass();
        check_table(m);
    endtask

    initial begin
        vec[0]  = '{0, 0, 0, 0, 32'h000B_0000};
        vec[1]  = '{0, 0, 0, 1, 32'h000D_0000};
        vec[2]  = '{0, 0, 1, 0, 32'h001F_0000};
        vec[3]  = '{0, 1, 0, 0, 32'h006F_0000};
        vec[4]  = '{0, 2, 3, 4, 32'h0117_0000};
        vec[5]  = '{0, 15, 4, 4, 32'h063F_0000};
        vec[6]  = '{1, 0, 0, 0, 32'h0005_0000};
        vec[7]  = '{1, 0, 0, 3, 32'h0005_0000};
        vec[8]  = '{1, 7, 2, 3, 32'h0005_0000};
        vec[9]  = '{2, 0, 0, 0, 32'hFFFF_0000};
        vec[10] = '{2, 0, 0, 1, 32'h7FFF_FFFF};
        vec[11] = '{2, 3, 1, 2, 32'hFFFF_0000};
        vec[12] = '{2, 15, 4, 4, 32'h7FFF_FFFF};

        clear_mon();
        repeat (3) tick();
        srstn = 1'b1;
        tick();
        check("rst_rd", 64'(dram_en_rd), 64'd0);
        check("rst_wr", 64'(dram_en_wr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr_in", 64'(addr_in), 64'd0);
        check("rst_addr_out", 64'(addr_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);

        // Ramp with timing and ignored mid-run enable pulses
        run_pass(0, 1'b1);
        run_pass(1, 1'b0);
        run_pass(2, 1'b0);

        // Synchronous abort at cycle 500
        mode = 0;
        start();
        tick();
        enable = 1'b0;
        wait_rel(500);
        srstn = 1'b0;
        abort_cyc = 500;
        tick();
        srstn = 1'b1;
        repeat (40) tick();
        check("abort_late_events", 64'(late_events), 64'd0);
        check("abort_done", 64'(done_count), 64'd0);
        check("abort_wr_count", 64'(wr_count), 64'd124);
        check("abort_rd_count", 64'(rd_count), 64'd500);
        run_pass(0, 1'b0);

        // Back-to-back passes with enable held high
        mode = 1;
        start();
        wait_done(1, 2000);
        wait_rel(1606);
        enable = 1'b0;
        wait_done(2, 2000);
        repeat (3) tick();
        check("b2b_done0", 64'(done_cyc0), 64'd1603);
        check("b2b_second_rd", 64'(rd_after_done), 64'd1605);
        check("b2b_done1", 64'(done_cyc1), 64'd3207);
        check("b2b_rd_count", 64'(rd_count), 64'd3200);
        check("b2b_wr_count", 64'(wr_count), 64'd800);
        check("b2b_done_count", 64'(done_count), 64'd2);
        check_table(1);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
